// File: rtl/ct_spsram_ctrl_pkg.sv
`default_nettype none
// ct_spsram_ctrl_pkg: shared constants and init-sweep state type for the 1024x92 SRAM controller.
// Rev 1.0
package ct_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 92;
  localparam int LANE_WIDTH = 23;
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } init_state_e;

endpackage
`default_nettype wire

// File: rtl/ct_spsram_rsp_fifo.sv
`default_nettype none
// ct_spsram_rsp_fifo: 2-entry valid/ready response buffer; push is never refused by construction.
// Rev 1.0
module ct_spsram_rsp_fifo
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             pop;

  assign out_vld_o  = (count_q != 2'd0);
  assign out_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign pop        = out_vld_o && out_rdy_i;
  assign count_d    = count_q + {1'b0, push_i} - {1'b0, pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ct_f_spsram_1024x92_ctrl.sv
`default_nettype none
// ct_f_spsram_1024x92_ctrl: round-robin write/read front end for a 1024x92 single-port SRAM macro.
// Define CT_SPSRAM_CTRL_INIT_EN to zero the array after reset before accepting requests. Rev 1.0
module ct_f_spsram_1024x92_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH,
  parameter int LANE_WIDTH = ct_spsram_ctrl_pkg::LANE_WIDTH
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             wr_vld,
  output logic                             wr_rdy,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
  input  logic                             rd_vld,
  output logic                             rd_rdy,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rsp_vld,
  input  logic                             rsp_rdy,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             init_done,
  output logic [ADDR_WIDTH-1:0]            A,
  output logic                             CEN,
  output logic                             GWEN,
  output logic [DATA_WIDTH-1:0]            WEN,
  output logic [DATA_WIDTH-1:0]            D,
  input  logic [DATA_WIDTH-1:0]            Q
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  inflight_q;
  logic                  rd_prio_q;
  logic                  rd_prio_d;
  logic [1:0]            fifo_count;
  logic [2:0]            outstanding;
  logic                  fifo_vld;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_gnt;
  logic                  rd_gnt;
  logic                  sweep_act;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  init_done_int;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  init_state_e           init_state_q;
  logic [ADDR_WIDTH-1:0] sweep_addr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_state_q <= SWEEP;
      sweep_addr_q <= '0;
    end else if (init_state_q == SWEEP) begin
      sweep_addr_q <= sweep_addr_q + 1'b1;
      if (&sweep_addr_q) begin
        init_state_q <= DONE;
      end
    end
  end

  assign sweep_act     = !RST && (init_state_q == SWEEP);
  assign sweep_addr    = sweep_addr_q;
  assign init_done_int = !RST && (init_state_q == DONE);
`else
  // Remembers that a reset has been seen so init_done is 1 from the first cycle after it.
  logic rst_seen_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_seen_q <= 1'b1;
    end
  end

  assign sweep_act     = 1'b0;
  assign sweep_addr    = '0;
  assign init_done_int = !RST && rst_seen_q;
`endif

  // Reads already in flight or buffered must leave room in the 2-entry FIFO.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign wr_ok       = wr_vld && init_done_int;
  assign rd_ok       = rd_vld && init_done_int && (outstanding < 3'(FIFO_DEPTH));
  assign wr_gnt      = wr_ok && (!rd_ok || !rd_prio_q);
  assign rd_gnt      = rd_ok && (!wr_ok || rd_prio_q);
  assign rd_prio_d   = (wr_gnt || rd_gnt) ? wr_gnt : rd_prio_q;

  assign wr_rdy    = wr_gnt;
  assign rd_rdy    = rd_gnt;
  assign init_done = init_done_int;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= 1'b0;
      rd_prio_q  <= 1'b0;
    end else begin
      inflight_q <= rd_gnt;
      rd_prio_q  <= rd_prio_d;
    end
  end

  always_comb begin
    A    = '0;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    D    = '0;
    if (sweep_act) begin
      A    = sweep_addr;
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
    end else if (wr_gnt) begin
      A    = wr_addr;
      CEN  = ~|wr_be;
      GWEN = 1'b0;
      D    = wr_data;
      for (int l = 0; l < LANES; l++) begin
        WEN[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~wr_be[l]}};
      end
    end else if (rd_gnt) begin
      A   = rd_addr;
      CEN = 1'b0;
    end
  end

  ct_spsram_rsp_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (inflight_q),
    .push_data_i(Q),
    .out_vld_o  (fifo_vld),
    .out_rdy_i  (rsp_rdy),
    .out_data_o (fifo_data),
    .count_o    (fifo_count)
  );

  assign rsp_vld  = fifo_vld && !RST;
  assign rsp_data = RST ? '0 : fifo_data;

endmodule
`default_nettype wire
